// File: rtl/fp_div32.sv
// Iterative IEEE-754 single-precision divider (z = a / b), radix-2 restoring, RNE, flush-to-zero.
// Define FP_DIV_FLAGS_EN to add the div_by_zero/overflow/underflow/invalid status outputs.
module fp_div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic        busy,
  output logic        output_ready
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
`endif
);

  localparam int ITER = 27;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPECIAL = 3'd1,
    S_DIVIDE  = 3'd2,
    S_NORM    = 3'd3,
    S_ROUND   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               s_q, s_d;
  logic signed [9:0]  e_q, e_d;
  logic [25:0]        rem_q, rem_d;
  logic [23:0]        dvs_q, dvs_d;
  logic [26:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [22:0]        mant_q, mant_d;
  logic               grd_q, grd_d;
  logic               rnd_q, rnd_d;
  logic               stk_q, stk_d;
  logic [31:0]        z_q, z_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
`ifdef FP_DIV_FLAGS_EN
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inv_q, inv_d;
`endif

  logic [7:0]         ea_s, eb_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic               nan_res_s, special_s, s_sp_s;
  logic [31:0]        sp_z_s;
  logic               rem_ge_s;
  logic [24:0]        rem_sub_s;
  logic [25:0]        qn_s;
  logic               inc_s;
  logic [23:0]        frac_sum_s;
  logic signed [9:0]  e_rnd_s;

  // Operand classification; exponent 0 is treated as zero regardless of mantissa.
  assign ea_s      = a_q[30:23];
  assign eb_s      = b_q[30:23];
  assign a_zero_s  = (ea_s == 8'd0);
  assign b_zero_s  = (eb_s == 8'd0);
  assign a_inf_s   = (ea_s == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf_s   = (eb_s == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan_s   = (ea_s == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan_s   = (eb_s == 8'hFF) && (b_q[22:0] != 23'd0);
  assign nan_res_s = a_nan_s | b_nan_s | (a_inf_s & b_inf_s) | (a_zero_s & b_zero_s);
  assign special_s = nan_res_s | a_inf_s | b_zero_s | a_zero_s | b_inf_s;
  assign s_sp_s    = a_q[31] ^ b_q[31];

  assign rem_ge_s  = (rem_q >= {2'b00, dvs_q});
  assign rem_sub_s = 25'(rem_q - {2'b00, dvs_q});

  // Normalising shift applied when the integer quotient bit is clear.
  assign qn_s       = quo_q[26] ? quo_q[25:0] : {quo_q[24:0], 1'b0};
  assign inc_s      = grd_q & (rnd_q | stk_q | mant_q[0]);
  assign frac_sum_s = {1'b0, mant_q} + {23'd0, inc_s};
  assign e_rnd_s    = frac_sum_s[23] ? (e_q + 10'sd1) : e_q;

  // Special-case result selection in priority order.
  always_comb begin
    sp_z_s = {s_sp_s, 31'd0};
    if (nan_res_s) begin
      sp_z_s = 32'hFFC00000;
    end else if (a_inf_s || b_zero_s) begin
      sp_z_s = {s_sp_s, 8'hFF, 23'd0};
    end else begin
      sp_z_s = {s_sp_s, 31'd0};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    e_d     = e_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    grd_d   = grd_q;
    rnd_d   = rnd_q;
    stk_d   = stk_q;
    z_d     = z_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
`ifdef FP_DIV_FLAGS_EN
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (en) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_SPECIAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SPECIAL: begin
        s_d = s_sp_s;
        if (special_s) begin
          z_d     = sp_z_s;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef FP_DIV_FLAGS_EN
          dbz_d   = ~nan_res_s & ~a_inf_s & b_zero_s;
          inv_d   = nan_res_s;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
`endif
        end else begin
          e_d     = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
          rem_d   = {2'b00, 1'b1, a_q[22:0]};
          dvs_d   = {1'b1, b_q[22:0]};
          quo_d   = 27'd0;
          cnt_d   = 5'd0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (rem_ge_s) begin
          quo_d = {quo_q[25:0], 1'b1};
          rem_d = {rem_sub_s, 1'b0};
        end else begin
          quo_d = {quo_q[25:0], 1'b0};
          rem_d = {rem_q[24:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = S_NORM;
        end else begin
          state_d = S_DIVIDE;
        end
      end
      S_NORM: begin
        if (!quo_q[26]) begin
          e_d = e_q - 10'sd1;
        end else begin
          e_d = e_q;
        end
        mant_d  = qn_s[25:3];
        grd_d   = qn_s[2];
        rnd_d   = qn_s[1];
        stk_d   = qn_s[0] | (rem_q != 26'd0);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (e_rnd_s >= 10'sd255) begin
          z_d = {s_q, 8'hFF, 23'd0};
        end else if (e_rnd_s <= 10'sd0) begin
          z_d = {s_q, 31'd0};
        end else begin
          z_d = {s_q, e_rnd_s[7:0], frac_sum_s[22:0]};
        end
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef FP_DIV_FLAGS_EN
        dbz_d   = 1'b0;
        inv_d   = 1'b0;
        ovf_d   = (e_rnd_s >= 10'sd255);
        unf_d   = (e_rnd_s <= 10'sd0);
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      s_q     <= 1'b0;
      e_q     <= 10'sd0;
      rem_q   <= 26'd0;
      dvs_q   <= 24'd0;
      quo_q   <= 27'd0;
      cnt_q   <= 5'd0;
      mant_q  <= 23'd0;
      grd_q   <= 1'b0;
      rnd_q   <= 1'b0;
      stk_q   <= 1'b0;
      z_q     <= 32'd0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      e_q     <= e_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      grd_q   <= grd_d;
      rnd_q   <= rnd_d;
      stk_q   <= stk_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
`ifdef FP_DIV_FLAGS_EN
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign z            = z_q;
  assign busy         = busy_q;
  assign output_ready = rdy_q;
`ifdef FP_DIV_FLAGS_EN
  assign div_by_zero  = dbz_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign invalid      = inv_q;
`endif

endmodule

// File: tb/tb_fp_div32.sv
// Scoreboard bench for fp_div32: stimulus pushes reference results, a monitor pops on output_ready.
module tb_fp_div32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic [31:0] z;
  logic        busy;
  logic        output_ready;
`ifdef FP_DIV_FLAGS_EN
  logic        div_by_zero, overflow, underflow, invalid;
`endif

  fp_div32 dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .a            (a_in),
    .b            (b_in),
    .z            (z),
    .busy         (busy),
    .output_ready (output_ready)
`ifdef FP_DIV_FLAGS_EN
    ,
    .div_by_zero  (div_by_zero),
    .overflow     (overflow),
    .underflow    (underflow),
    .invalid      (invalid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [3:0]  fl;   // {div_by_zero, overflow, underflow, invalid}
    int          t0;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: exact integer quotient with remainder, then round-to-nearest-even.
  task automatic ref_div(input logic [31:0] ra, input logic [31:0] rb,
                         output logic [31:0] rz, output logic [3:0] fl, output int lat);
    logic        s, az, bz, ainf, binf, anan, bnan, g, st;
    logic [63:0] ma, mb, num, q, r, m;
    int          e;
    s    = ra[31] ^ rb[31];
    az   = (ra[30:23] == 8'd0);
    bz   = (rb[30:23] == 8'd0);
    ainf = (ra[30:23] == 8'hFF) && (ra[22:0] == 23'd0);
    binf = (rb[30:23] == 8'hFF) && (rb[22:0] == 23'd0);
    anan = (ra[30:23] == 8'hFF) && (ra[22:0] != 23'd0);
    bnan = (rb[30:23] == 8'hFF) && (rb[22:0] != 23'd0);
    lat  = 1;
    fl   = 4'b0000;
    if (anan || bnan || (ainf && binf) || (az && bz)) begin
      rz = 32'hFFC00000; fl = 4'b0001;
    end else if (ainf) begin
      rz = {s, 8'hFF, 23'd0};
    end else if (bz) begin
      rz = {s, 8'hFF, 23'd0}; fl = 4'b1000;
    end else if (az || binf) begin
      rz = {s, 31'd0};
    end else begin
      lat = 30;
      ma  = {40'd0, 1'b1, ra[22:0]};
      mb  = {40'd0, 1'b1, rb[22:0]};
      num = ma << 25;
      q   = num / mb;
      r   = num % mb;
      e   = int'(ra[30:23]) - int'(rb[30:23]) + 127;
      if (q >= 64'd33554432) begin
        m = q >> 2; g = q[1]; st = q[0] | (r != 64'd0);
      end else begin
        m = q >> 1; g = q[0]; st = (r != 64'd0); e = e - 1;
      end
      if (g && (st || m[0])) m = m + 64'd1;
      if (m == 64'd16777216) begin
        m = 64'd8388608; e = e + 1;
      end
      if (e >= 255) begin
        rz = {s, 8'hFF, 23'd0}; fl = 4'b0100;
      end else if (e <= 0) begin
        rz = {s, 31'd0}; fl = 4'b0010;
      end else begin
        rz = {s, e[7:0], m[22:0]};
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] pa, input logic [31:0] pb, input int t0, output int due);
    exp_t e;
    int   lat;
    ref_div(pa, pb, e.z, e.fl, lat);
    e.a = pa; e.b = pb; e.t0 = t0; e.due = t0 + lat;
    due = e.due;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL idle_timeout busy=%0b required=0", busy);
      $fatal(1, "busy stuck high");
    end
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, output int t0);
    int due;
    wait_idle();
    a_in = ta; b_in = tb; en = 1'b1;
    t0 = cyc + 1;
    push_exp(ta, tb, t0, due);
    @(negedge clk);
    en = 1'b0;
    a_in = $urandom; b_in = $urandom;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      2: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      3: r[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'h01;
      4: r[22:0] = 23'd0;
      default: if (r[30:23] == 8'hFF) r[30:23] = 8'h80;
    endcase
    return r;
  endfunction

  // Monitor: compares each result against the queue head and tracks expected busy.
  initial begin
    exp_t e;
    logic exp_busy;
    logic prev_rst;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rst = 1'b1;
      end else begin
        if (prev_rst) begin
          checks++;
          if (z !== 32'd0 || output_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state z=%h ready=%0b required z=00000000 ready=0", z, output_ready);
          end
          prev_rst = 1'b0;
        end
        if (output_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_ready at cycle %0d z=%h required no output", cyc, z);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (z !== e.z) begin
              errors++;
              $display("FAIL z_value a=%h b=%h got=%h required=%h", e.a, e.b, z, e.z);
            end
            checks++;
            if (cyc != e.due) begin
              errors++;
              $display("FAIL latency a=%h b=%h got=%0d required=%0d", e.a, e.b, cyc - e.t0, e.due - e.t0);
            end
`ifdef FP_DIV_FLAGS_EN
            checks++;
            if ({div_by_zero, overflow, underflow, invalid} !== e.fl) begin
              errors++;
              $display("FAIL flags a=%h b=%h got=%b required=%b", e.a, e.b,
                       {div_by_zero, overflow, underflow, invalid}, e.fl);
            end
`endif
          end
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_result a=%h b=%h got=none required=%h", e.a, e.b, e.z);
        end
        exp_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].t0) && (cyc < exp_q[0].due);
        checks++;
        if (busy !== exp_busy) begin
          errors++;
          $display("FAIL busy at cycle %0d got=%0b required=%0b", cyc, busy, exp_busy);
        end
      end
    end
  end

  logic [31:0] dir_a [14] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                              32'h00000000, 32'h7F800000, 32'h7FC00001, 32'h7F000000,
                              32'h00800000, 32'h00000001, 32'h3F800000, 32'h7F7FFFFF,
                              32'h00000000, 32'h3F800000};
  logic [31:0] dir_b [14] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                              32'h00000000, 32'hC0000000, 32'h12345678, 32'h00800000,
                              32'h7F000000, 32'h3F800000, 32'h3F800000, 32'h3F7FFFFF,
                              32'h7F800000, 32'hFF800000};

  // Stimulus: directed cases, held-enable, mid-operation reset, then random operands.
  initial begin
    int t0, due1, due2, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) issue(dir_a[i], dir_b[i], t0);

    // en held high: second op accepted only after the first completes
    wait_idle();
    a_in = 32'h40C00000; b_in = 32'h40000000; en = 1'b1;
    push_exp(32'h40C00000, 32'h40000000, cyc + 1, due1);
    @(negedge clk);
    a_in = 32'h3F800000; b_in = 32'h40400000;
    push_exp(32'h3F800000, 32'h40400000, due1 + 1, due2);
    n = 0;
    while (cyc != due1 + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;

    // reset at the tenth edge after accept aborts silently
    issue(32'h40C00000, 32'h40000000, t0);
    n = 0;
    while (cyc != t0 + 9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h40C00000, 32'h40000000, t0);

    for (int i = 0; i < 150; i++) issue(rand_op(), rand_op(), t0);

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
